// File: rtl/meas_pkg.sv
// Shared types and constants for the strobe capture controller.
package meas_pkg;

    // Depth of the synchroniser placed on the asynchronous comparator output.
    localparam int CMP_SYNC_STAGES = 2;

    // One-hot controller states, in burst order.
    typedef enum logic [7:0] {
        ST_IDLE       = 8'b0000_0001,
        ST_WAIT_RDY   = 8'b0000_0010,
        ST_REQ        = 8'b0000_0100,
        ST_WAIT_CLR   = 8'b0000_1000,
        ST_WAIT_VALID = 8'b0001_0000,
        ST_SETTLE     = 8'b0010_0000,
        ST_SAMPLE     = 8'b0100_0000,
        ST_DONE       = 8'b1000_0000
    } stb_cap_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for asynchronous inputs.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q_o = stage_r[STAGES-1];

endmodule

// File: rtl/stb_capture_ctrl.sv
// Strobe capture controller: requests strobes from the strobe generator,
// samples the synchronised comparator after each strobe and counts hits
// over a burst of N strobes for threshold calibration.
module stb_capture_ctrl
    import meas_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int TO_WIDTH   = 24,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CNT_WIDTH-1:0] n_samples_i,
    input  logic [TO_WIDTH-1:0]  timeout_i,
    input  logic                 stb_rdy_i,
    input  logic                 stb_valid_i,
    output logic                 stb_req_o,
    input  logic                 cmp_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] sample_cnt_o
);

    // Settle counter only needs to hold SETTLE_CYC-1.
    localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

    stb_cap_state_t       state_r;
    stb_cap_state_t       next_s;
    logic [CNT_WIDTH-1:0] n_lat_r;
    logic [TO_WIDTH-1:0]  to_lat_r;
    logic [TO_WIDTH-1:0]  to_cnt_r;
    logic [SW-1:0]        settle_cnt_r;
    logic [CNT_WIDTH-1:0] hit_r;
    logic [CNT_WIDTH-1:0] sample_r;
    logic                 busy_r;
    logic                 timeout_r;
    logic                 cmp_sync_s;
    logic                 start_s;
    logic                 expire_s;
    logic                 last_s;
    logic                 timeout_hit_s;

    // Saturating increment so the result counters can never wrap.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic                 inc);
        if (inc && (v != {CNT_WIDTH{1'b1}})) begin
            return v + CNT_WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    sync_ff #(
        .WIDTH  (1),
        .STAGES (CMP_SYNC_STAGES)
    ) u_cmp_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (cmp_i),
        .q_o    (cmp_sync_s)
    );

    // An abort in IDLE suppresses a simultaneous start.
    assign start_s  = start_i && !abort_i;
    // Timer expires on the cycle it would decrement to zero; 0 disables it.
    assign expire_s = (to_lat_r != {TO_WIDTH{1'b0}}) && (to_cnt_r == TO_WIDTH'(1));
    assign last_s   = (({1'b0, sample_r} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, n_lat_r});

    // Next-state decode; abort overrides every other transition of a burst.
    always_comb begin
        next_s        = state_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_s = ST_WAIT_RDY;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (abort_i) begin
                    next_s = ST_DONE;
                end else if (expire_s) begin
                    next_s        = ST_DONE;
                    timeout_hit_s = 1'b1;
                end else if (stb_rdy_i) begin
                    next_s = ST_REQ;
                end else begin
                    next_s = ST_WAIT_RDY;
                end
            end
            ST_REQ: begin
                if (abort_i) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                if (abort_i) begin
                    next_s = ST_DONE;
                end else if (expire_s) begin
                    next_s        = ST_DONE;
                    timeout_hit_s = 1'b1;
                end else if (!stb_valid_i) begin
                    next_s = ST_WAIT_VALID;
                end else begin
                    next_s = ST_WAIT_CLR;
                end
            end
            ST_WAIT_VALID: begin
                if (abort_i) begin
                    next_s = ST_DONE;
                end else if (expire_s) begin
                    next_s        = ST_DONE;
                    timeout_hit_s = 1'b1;
                end else if (stb_valid_i) begin
                    next_s = (SETTLE_CYC > 1) ? ST_SETTLE : ST_SAMPLE;
                end else begin
                    next_s = ST_WAIT_VALID;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    next_s = ST_DONE;
                end else if (settle_cnt_r <= SW'(1)) begin
                    next_s = ST_SAMPLE;
                end else begin
                    next_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (abort_i || last_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_REQ;
                end
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Burst configuration, timeout/settle timers, result counters and flags.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            n_lat_r      <= {CNT_WIDTH{1'b0}};
            to_lat_r     <= {TO_WIDTH{1'b0}};
            to_cnt_r     <= {TO_WIDTH{1'b0}};
            settle_cnt_r <= {SW{1'b0}};
            hit_r        <= {CNT_WIDTH{1'b0}};
            sample_r     <= {CNT_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        n_lat_r   <= (n_samples_i == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : n_samples_i;
                        to_lat_r  <= timeout_i;
                        to_cnt_r  <= timeout_i;
                        hit_r     <= {CNT_WIDTH{1'b0}};
                        sample_r  <= {CNT_WIDTH{1'b0}};
                        timeout_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_WAIT_RDY, ST_WAIT_CLR, ST_WAIT_VALID: begin
                    if (to_cnt_r != {TO_WIDTH{1'b0}}) begin
                        to_cnt_r <= to_cnt_r - TO_WIDTH'(1);
                    end
                    if (next_s == ST_SETTLE) begin
                        settle_cnt_r <= SW'(SETTLE_CYC - 1);
                    end
                end
                ST_REQ: begin
                    to_cnt_r <= to_lat_r;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r != {SW{1'b0}}) begin
                        settle_cnt_r <= settle_cnt_r - SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    sample_r <= sat_inc(sample_r, 1'b1);
                    hit_r    <= sat_inc(hit_r, cmp_sync_s);
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign stb_req_o    = (state_r == ST_REQ);
    assign done_o       = (state_r == ST_DONE);
    assign busy_o       = busy_r;
    assign timeout_o    = timeout_r;
    assign hit_cnt_o    = hit_r;
    assign sample_cnt_o = sample_r;

endmodule

// File: tb/tb_stb_capture_ctrl.sv
// Self-checking bench for stb_capture_ctrl with a strobe generator model.
module tb_stb_capture_ctrl;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        start_i;
    logic        abort_i;
    logic [15:0] n_samples_i;
    logic [23:0] timeout_i;
    logic        stb_rdy_i;
    logic        stb_valid_i;
    logic        stb_req_o;
    logic        cmp_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [15:0] hit_cnt_o;
    logic [15:0] sample_cnt_o;

    // generator model controls / state
    logic gen_en, gen_valid, gen_cmp, man_valid, man_cmp;
    int   gen_delay, gen_hold;
    int   dly_left, hold_left;
    int   strobe_cnt, pat_base;
    bit   pat [64];

    int   req_cnt, done_cnt;
    int   total, n_pass, n_fail;

    assign stb_valid_i = gen_valid | man_valid;
    assign cmp_i       = gen_en ? gen_cmp : man_cmp;

    stb_capture_ctrl dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .n_samples_i  (n_samples_i),
        .timeout_i    (timeout_i),
        .stb_rdy_i    (stb_rdy_i),
        .stb_valid_i  (stb_valid_i),
        .stb_req_o    (stb_req_o),
        .cmp_i        (cmp_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .hit_cnt_o    (hit_cnt_o),
        .sample_cnt_o (sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Strobe generator: valid rises gen_delay cycles after a request and
    // stays high gen_hold cycles; cmp follows the per-strobe pattern.
    initial begin
        gen_valid = 1'b0; gen_cmp = 1'b0;
        dly_left = 0; hold_left = 0; strobe_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) gen_valid = 1'b0;
            end
            if (dly_left > 0) begin
                dly_left--;
                if (dly_left == 0) begin
                    gen_valid = 1'b1;
                    gen_cmp   = pat[(strobe_cnt - pat_base) % 64];
                    strobe_cnt++;
                    hold_left = gen_hold;
                end
            end
            if (gen_en && stb_req_o) dly_left = gen_delay;
        end
    end

    // Event monitor: counts request and done pulses.
    initial begin
        req_cnt = 0; done_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (stb_req_o) req_cnt++;
            if (done_o) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic kick(input int n, input int to);
        pat_base = strobe_cnt;
        @(negedge clk_i);
        n_samples_i = 16'(n);
        timeout_i   = 24'(to);
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit got);
        cycles = 0; got = 1'b0;
        while (!got && cycles < budget) begin
            if (done_o) got = 1'b1;
            else begin
                @(negedge clk_i);
                cycles++;
            end
        end
    endtask

    task automatic wait_strobes(input int k, input int budget, output bit got);
        int c = 0;
        while ((strobe_cnt - pat_base) < k && c < budget) begin
            @(negedge clk_i);
            c++;
        end
        got = ((strobe_cnt - pat_base) >= k);
    endtask

    task automatic man_strobe(input logic c);
        repeat (3) @(negedge clk_i);
        man_valid = 1'b1; man_cmp = c;
        repeat (2) @(negedge clk_i);
        man_valid = 1'b0;
    endtask

    initial begin
        int  cyc, r0, d0, n, neff, to, exp_hit, c;
        bit  got;
        total = 0; n_pass = 0; n_fail = 0;
        arst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        n_samples_i = 16'd0; timeout_i = 24'd0; stb_rdy_i = 1'b1;
        man_valid = 1'b0; man_cmp = 1'b0; gen_en = 1'b1;
        gen_delay = 10; gen_hold = 2; pat_base = 0;
        for (int i = 0; i < 64; i++) pat[i] = 1'b1;

        // reset state
        repeat (3) @(negedge clk_i);
        check("rst_flags", {28'd0, busy_o, done_o, stb_req_o, timeout_o}, 32'd0);
        check("rst_hit", {16'd0, hit_cnt_o}, 32'd0);
        check("rst_sample", {16'd0, sample_cnt_o}, 32'd0);
        arst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // n=4, all hits
        r0 = req_cnt; d0 = done_cnt;
        kick(4, 0);
        wait_done(400, cyc, got);
        check("t1_done", {31'd0, got}, 32'd1);
        check("t1_hit", {16'd0, hit_cnt_o}, 32'd4);
        check("t1_sample", {16'd0, sample_cnt_o}, 32'd4);
        check("t1_req", req_cnt - r0, 32'd4);
        @(negedge clk_i);
        check("t1_busy_done", {30'd0, busy_o, done_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        check("t1_done_pulses", done_cnt - d0, 32'd1);

        // n=8, alternating comparator
        for (int i = 0; i < 64; i++) pat[i] = (i % 2 == 0);
        kick(8, 0);
        wait_done(600, cyc, got);
        check("t2_done", {31'd0, got}, 32'd1);
        check("t2_hit", {16'd0, hit_cnt_o}, 32'd4);
        check("t2_sample", {16'd0, sample_cnt_o}, 32'd8);
        check("t2_tmo", {31'd0, timeout_o}, 32'd0);

        // generator never ready, timeout 100
        stb_rdy_i = 1'b0;
        r0 = req_cnt;
        kick(4, 100);
        wait_done(300, cyc, got);
        check("t3_done", {31'd0, got}, 32'd1);
        check("t3_window", {31'd0, (cyc >= 95 && cyc <= 110)}, 32'd1);
        check("t3_tmo", {31'd0, timeout_o}, 32'd1);
        check("t3_sample", {16'd0, sample_cnt_o}, 32'd0);
        check("t3_req", req_cnt - r0, 32'd0);
        stb_rdy_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // valid stuck high from before the burst
        gen_en = 1'b0; man_valid = 1'b1;
        r0 = req_cnt;
        kick(2, 0);
        repeat (20) @(negedge clk_i);
        check("t4_req_stuck", req_cnt - r0, 32'd1);
        check("t4_sample_stuck", {16'd0, sample_cnt_o}, 32'd0);
        check("t4_busy", {31'd0, busy_o}, 32'd1);
        check("t4_tmo_clr", {31'd0, timeout_o}, 32'd0);
        man_valid = 1'b0;
        man_strobe(1'b1);
        c = 0;
        while (!stb_req_o && c < 50) begin @(negedge clk_i); c++; end
        check("t4_req2_seen", {31'd0, stb_req_o}, 32'd1);
        man_strobe(1'b0);
        wait_done(50, cyc, got);
        check("t4_done", {31'd0, got}, 32'd1);
        check("t4_sample", {16'd0, sample_cnt_o}, 32'd2);
        check("t4_hit", {16'd0, hit_cnt_o}, 32'd1);
        check("t4_req", req_cnt - r0, 32'd2);
        gen_en = 1'b1;
        repeat (2) @(negedge clk_i);

        // abort during third settle window
        for (int i = 0; i < 64; i++) pat[i] = 1'b1;
        kick(10, 0);
        wait_strobes(3, 200, got);
        check("t5_third_strobe", {31'd0, got}, 32'd1);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("t5_done", {31'd0, done_o}, 32'd1);
        check("t5_sample", {16'd0, sample_cnt_o}, 32'd2);
        @(negedge clk_i);
        check("t5_busy_tmo", {30'd0, busy_o, timeout_o}, 32'd0);
        repeat (20) @(negedge clk_i);

        // asynchronous reset mid-burst, then n=0 burst
        kick(10, 0);
        wait_strobes(2, 200, got);
        @(negedge clk_i);
        d0 = done_cnt;
        arst_i = 1'b1;
        #1;
        check("t6_rst_flags", {28'd0, busy_o, done_o, stb_req_o, timeout_o}, 32'd0);
        check("t6_rst_cnts", {hit_cnt_o, sample_cnt_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
        repeat (30) @(negedge clk_i);
        check("t6_no_done", done_cnt - d0, 32'd0);
        r0 = req_cnt;
        kick(0, 0);
        wait_done(200, cyc, got);
        check("t6_done", {31'd0, got}, 32'd1);
        check("t6_sample", {16'd0, sample_cnt_o}, 32'd1);
        check("t6_hit", {16'd0, hit_cnt_o}, 32'd1);
        check("t6_req", req_cnt - r0, 32'd1);
        repeat (2) @(negedge clk_i);

        // randomized bursts against the counting model
        for (int it = 0; it < 8; it++) begin
            n         = int'($urandom_range(0, 12));
            gen_delay = int'($urandom_range(3, 15));
            gen_hold  = int'($urandom_range(1, gen_delay - 1));
            to        = (it % 2 == 1) ? 1000 : 0;
            for (int i = 0; i < 64; i++) pat[i] = bit'($urandom_range(0, 1));
            neff    = (n == 0) ? 1 : n;
            exp_hit = 0;
            for (int i = 0; i < neff; i++) exp_hit += int'(pat[i]);
            r0 = req_cnt;
            kick(n, to);
            wait_done(neff * 30 + 50, cyc, got);
            check("rnd_done", {31'd0, got}, 32'd1);
            check("rnd_sample", {16'd0, sample_cnt_o}, 32'(neff));
            check("rnd_hit", {16'd0, hit_cnt_o}, 32'(exp_hit));
            check("rnd_req", req_cnt - r0, 32'(neff));
            check("rnd_tmo", {31'd0, timeout_o}, 32'd0);
            repeat (gen_hold + 2) @(negedge clk_i);
        end

        $display("%0d/%0d checks passed", n_pass, total);
        $finish;
    end

endmodule
